// File: rtl/idli_sqi_ctrl_m.sv
// SQI SRAM transaction sequencer: turns core read/write requests into quad-mode
// command, address, dummy and data phases, owning chip-select and pin direction.
module idli_sqi_ctrl_m (
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst_n,
  input  logic        i_sqi_req,
  input  logic        i_sqi_wr,
  input  logic [15:0] i_sqi_addr,
  output logic        o_sqi_req_acp,
  input  logic        i_sqi_end,
  input  logic [3:0]  i_sqi_wdata,
  output logic        o_sqi_wdata_acp,
  output logic [3:0]  o_sqi_rdata,
  output logic        o_sqi_rdata_vld,
  output logic        o_sqi_cs,
  output logic        o_sqi_io_mode,
  output logic [3:0]  o_sqi_sio,
  input  logic [3:0]  i_sqi_sio
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DESEL
  } state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [15:0] addr_q;
  logic        wr_q;
  logic [3:0]  addr_nib_next;

  // Accepts are gated by reset so nothing is handshaken while the block is held.
  always_comb begin
    o_sqi_req_acp   = i_sqi_rst_n && (state == ST_IDLE) && i_sqi_req;
    o_sqi_wdata_acp = i_sqi_rst_n && wr_q &&
                      (((state == ST_ADDR) && (cnt == 2'd3)) ||
                       ((state == ST_DATA) && !i_sqi_end));
  end

  // Address nibble to present after the current ADDR cycle.
  always_comb begin
    case (cnt)
      2'd0:    addr_nib_next = addr_q[11:8];
      2'd1:    addr_nib_next = addr_q[7:4];
      default: addr_nib_next = addr_q[3:0];
    endcase
  end

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      addr_q          <= '0;
      wr_q            <= 1'b0;
      o_sqi_cs        <= 1'b1;
      o_sqi_io_mode   <= 1'b1;
      o_sqi_sio       <= '0;
      o_sqi_rdata     <= '0;
      o_sqi_rdata_vld <= 1'b0;
    end else begin
      o_sqi_rdata_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          o_sqi_cs      <= 1'b1;
          o_sqi_io_mode <= 1'b1;
          o_sqi_sio     <= '0;
          if (i_sqi_req) begin
            addr_q   <= i_sqi_addr;
            wr_q     <= i_sqi_wr;
            cnt      <= '0;
            o_sqi_cs <= 1'b0;
            state    <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (cnt == 2'd0) begin
            o_sqi_sio <= wr_q ? 4'h2 : 4'h3;
            cnt       <= 2'd1;
          end else begin
            o_sqi_sio <= addr_q[15:12];
            cnt       <= '0;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (cnt != 2'd3) begin
            o_sqi_sio <= addr_nib_next;
            cnt       <= cnt + 2'd1;
          end else if (wr_q) begin
            o_sqi_sio <= i_sqi_wdata;
            state     <= ST_DATA;
          end else begin
            o_sqi_sio     <= '0;
            o_sqi_io_mode <= 1'b0;
            cnt           <= '0;
            state         <= ST_DUMMY;
          end
        end
        ST_DUMMY: begin
          if (cnt == 2'd0) begin
            cnt <= 2'd1;
          end else begin
            cnt   <= '0;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!wr_q) begin
            o_sqi_rdata     <= i_sqi_sio;
            o_sqi_rdata_vld <= 1'b1;
          end
          if (i_sqi_end) begin
            o_sqi_cs      <= 1'b1;
            o_sqi_io_mode <= 1'b1;
            o_sqi_sio     <= '0;
            state         <= ST_DESEL;
          end else if (wr_q) begin
            o_sqi_sio <= i_sqi_wdata;
          end
        end
        ST_DESEL: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Randomized bench for idli_sqi_ctrl_m: each transaction's per-cycle pin activity
// is derived from the cycle index relative to the accept cycle.
module tb_idli_sqi_ctrl_m;

  logic        gck = 1'b0;
  logic        rst_n;
  logic        req;
  logic        wr;
  logic [15:0] addr;
  logic        req_acp;
  logic        sqi_end;
  logic [3:0]  wdata;
  logic        wdata_acp;
  logic [3:0]  rdata;
  logic        rdata_vld;
  logic        cs;
  logic        io_mode;
  logic [3:0]  sio_o;
  logic [3:0]  sio_i;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [3:0]  d [16];

  idli_sqi_ctrl_m dut (
    .i_sqi_gck       (gck),
    .i_sqi_rst_n     (rst_n),
    .i_sqi_req       (req),
    .i_sqi_wr        (wr),
    .i_sqi_addr      (addr),
    .o_sqi_req_acp   (req_acp),
    .i_sqi_end       (sqi_end),
    .i_sqi_wdata     (wdata),
    .o_sqi_wdata_acp (wdata_acp),
    .o_sqi_rdata     (rdata),
    .o_sqi_rdata_vld (rdata_vld),
    .o_sqi_cs        (cs),
    .o_sqi_io_mode   (io_mode),
    .o_sqi_sio       (sio_o),
    .i_sqi_sio       (sio_i)
  );

  always #5 gck = ~gck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_noise();
    req     = 1'($urandom_range(0, 1));
    wr      = 1'($urandom_range(0, 1));
    addr    = 16'($urandom);
    sqi_end = 1'($urandom_range(0, 1));
    wdata   = 4'($urandom);
    sio_i   = 4'($urandom);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      drive_noise();
      req = 1'b0;
      @(negedge gck);
      chk("idle_cs", 32'(cs), 32'd1);
      chk("idle_io", 32'(io_mode), 32'd1);
      chk("idle_sio", 32'(sio_o), 32'd0);
      chk("idle_racp", 32'(req_acp), 32'd0);
      chk("idle_wacp", 32'(wdata_acp), 32'd0);
      chk("idle_vld", 32'(rdata_vld), 32'd0);
      @(posedge gck);
      #1;
    end
  endtask

  // Cycle 0 is the accept cycle; cycle k follows the k-th edge after it.
  task automatic run_txn(input bit t_wr, input logic [15:0] t_addr, input int n,
                         input bit b2b, input bit n_wr, input logic [15:0] n_addr,
                         input int abort_at);
    int last, dend, dbeg;
    logic [3:0] es;
    logic ecs, eio, ew, ev;
    last = t_wr ? 7 + n : 9 + n;
    dend = t_wr ? 6 + n : 8 + n;
    dbeg = dend - n + 1;
    for (int c = 0; c <= last; c++) begin
      drive_noise();
      if (c == 0) begin
        req = 1'b1; wr = t_wr; addr = t_addr;
      end
      if (c == last && b2b) begin
        req = 1'b1; wr = n_wr; addr = n_addr;
      end
      if (c >= dbeg && c <= dend) sqi_end = (c == dend);
      ew = t_wr && c >= 6 && c <= 5 + n;
      if (ew) wdata = d[c-6];
      if (!t_wr && c >= 9 && c <= 8 + n) sio_i = d[c-9];
      ecs = !(c >= 1 && c < last);
      eio = t_wr || !(c >= 7 && c < last);
      es = 4'h0;
      if (c == 2) es = t_wr ? 4'h2 : 4'h3;
      if (c >= 3 && c <= 6) es = t_addr[4*(6-c) +: 4];
      if (t_wr && c >= 7 && c <= dend) es = d[c-7];
      ev = !t_wr && c >= 10 && c <= 9 + n;
      @(negedge gck);
      chk("cs", 32'(cs), 32'(ecs));
      chk("io_mode", 32'(io_mode), 32'(eio));
      chk("sio", 32'(sio_o), 32'(es));
      chk("req_acp", 32'(req_acp), 32'(c == 0));
      chk("wdata_acp", 32'(wdata_acp), 32'(ew));
      chk("rdata_vld", 32'(rdata_vld), 32'(ev));
      if (ev) chk("rdata", 32'(rdata), 32'(d[c-10]));
      if (c == abort_at) begin
        req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_io", 32'(io_mode), 32'd1);
        chk("rst_sio", 32'(sio_o), 32'd0);
        chk("rst_racp", 32'(req_acp), 32'd0);
        chk("rst_vld", 32'(rdata_vld), 32'd0);
        @(posedge gck);
        #1;
        rst_n = 1'b1;
        req   = 1'b0;
        return;
      end
      @(posedge gck);
      #1;
    end
  endtask

  initial begin
    bit c_wr, x_wr, b2b;
    logic [15:0] c_addr, x_addr;
    int c_n;
    rst_n = 1'b0;
    drive_noise();
    req = 1'b1;
    #12;
    chk("reset_cs", 32'(cs), 32'd1);
    chk("reset_io", 32'(io_mode), 32'd1);
    chk("reset_sio", 32'(sio_o), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    chk("reset_vld", 32'(rdata_vld), 32'd0);
    chk("reset_racp", 32'(req_acp), 32'd0);
    chk("reset_wacp", 32'(wdata_acp), 32'd0);
    @(posedge gck);
    #1;
    rst_n = 1'b1;
    idle(2);

    d[0] = 4'hA; d[1] = 4'hB; d[2] = 4'hC;
    run_txn(1'b1, 16'h1234, 3, 1'b0, 1'b0, 16'h0, -1);
    idle(2);
    d[0] = 4'h5; d[1] = 4'h6;
    run_txn(1'b0, 16'h00FF, 2, 1'b0, 1'b0, 16'h0, -1);
    idle(2);
    d[0] = 4'h9; d[1] = 4'h3;
    run_txn(1'b1, 16'hBEEF, 2, 1'b1, 1'b0, 16'h4321, -1);
    d[0] = 4'h7; d[1] = 4'hE;
    run_txn(1'b0, 16'h4321, 2, 1'b0, 1'b0, 16'h0, -1);
    idle(2);
    d[0] = 4'hD;
    run_txn(1'b1, 16'h0F0F, 1, 1'b0, 1'b0, 16'h0, -1);
    idle(2);
    run_txn(1'b0, 16'hA5C3, 4, 1'b0, 1'b0, 16'h0, 5);
    idle(1);
    d[0] = 4'h1; d[1] = 4'h2; d[2] = 4'hF;
    run_txn(1'b0, 16'h0010, 3, 1'b0, 1'b0, 16'h0, -1);
    idle(1);

    c_wr = 1'($urandom_range(0, 1));
    c_addr = 16'($urandom);
    for (int t = 0; t < 40; t++) begin
      c_n = $urandom_range(1, 6);
      for (int j = 0; j < 16; j++) d[j] = 4'($urandom);
      x_wr = 1'($urandom_range(0, 1));
      x_addr = 16'($urandom);
      b2b = 1'($urandom_range(0, 1));
      run_txn(c_wr, c_addr, c_n, b2b, x_wr, x_addr, -1);
      if (!b2b) idle($urandom_range(1, 3));
      c_wr = x_wr;
      c_addr = x_addr;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/idli_sqi_ctrl_m.md
# idli_sqi_ctrl_m

SQI SRAM transaction sequencer sitting directly downstream of the core's memory port. Turns a core-side request (16-bit nibble address, read/write, nibble data streams) into quad-mode command/address/dummy/data phases on the external SRAM pins. It owns chip-select, pin direction and nibble sequencing so the core only handles valid/accept handshakes. The memory clock is `i_sqi_gck` forwarded at top level; this block does not generate it.

## Interface

- No parameters.
- Clocking: one clock; reset is asynchronous and active-low.
- `i_sqi_gck`  in  1  clock; all state and outputs update on its rising edge.
- `i_sqi_rst_n`  in  1  asynchronous active-low reset.
- `i_sqi_req`  in  1  transaction request, held until accepted.
- `i_sqi_wr`  in  1  1 = write, 0 = read; qualified by `i_sqi_req`.
- `i_sqi_addr`  in  16  start address; qualified by `i_sqi_req`.
- `o_sqi_req_acp`  out  1  request accepted; combinational; high only in IDLE with `i_sqi_req`.
- `i_sqi_end`  in  1  the current DATA cycle is the last.
- `i_sqi_wdata`  in  4  write nibble.
- `o_sqi_wdata_acp`  out  1  `i_sqi_wdata` is captured at this edge; combinational.
- `o_sqi_rdata`  out  4  registered read nibble.
- `o_sqi_rdata_vld`  out  1  `o_sqi_rdata` is valid this cycle; one-cycle pulse per nibble; no backpressure.
- `o_sqi_cs`  out  1  SRAM chip select, active low, registered.
- `o_sqi_io_mode`  out  1  1 = pins driven (output), 0 = input; registered.
- `o_sqi_sio`  out  4  registered output nibble.
- `i_sqi_sio`  in  4  input nibble from the SRAM.

## Operation

- States: IDLE, CMD (2 cycles), ADDR (4 cycles), DUMMY (2 cycles, read only), DATA (open-ended), DESEL (1 cycle). A 2-bit counter indexes the nibbles within CMD, ADDR and DUMMY.
- **IDLE:** `o_sqi_cs` = 1, `o_sqi_io_mode` = 1, `o_sqi_sio` = 0. On an edge with `i_sqi_req`:
  - latch `i_sqi_addr` and `i_sqi_wr`;
  - go to CMD.
- **CMD:** `o_sqi_cs` = 0. `o_sqi_sio` = 0x0, then 0x3 for a read or 0x2 for a write (command byte sent high nibble first).
- **ADDR:** `o_sqi_sio` = addr[15:12], [11:8], [7:4], [3:0] on consecutive cycles.
- **Write path:** on the edge leaving the last ADDR cycle, `o_sqi_wdata_acp` = 1 and `i_sqi_wdata` is registered to `o_sqi_sio`; go to DATA.
- **Read path:** after ADDR, go to DUMMY. `o_sqi_io_mode` = 0 from the first DUMMY cycle, `o_sqi_sio` = 0. Then go to DATA.
- **DATA, write:** each cycle the driven nibble is presented.
  - If `i_sqi_end` = 0: `o_sqi_wdata_acp` = 1 and the next nibble is captured.
  - If `i_sqi_end` = 1: `o_sqi_wdata_acp` = 0; go to DESEL.
- **DATA, read:** each edge registers `i_sqi_sio` into `o_sqi_rdata` and sets `o_sqi_rdata_vld` = 1 for the following cycle. When `i_sqi_end` = 1, go to DESEL; the nibble captured on that edge is still delivered.
- **DESEL:** `o_sqi_cs` = 1, `o_sqi_io_mode` = 1, `o_sqi_sio` = 0. Always return to IDLE; a new request cannot be accepted before that IDLE cycle, which guarantees at least 2 cycles of CS high.
- Address increment is the SRAM's job in sequential mode; this block holds no data address counter.
- `i_sqi_req` outside IDLE is ignored. `i_sqi_end` outside DATA is ignored. `i_sqi_wdata` is ignored when `o_sqi_wdata_acp` = 0.

## Timing

- **Reset values (asynchronous, immediate):** state IDLE, `o_sqi_cs` = 1, `o_sqi_io_mode` = 1, `o_sqi_sio` = 0, `o_sqi_rdata` = 0, `o_sqi_rdata_vld` = 0. Combinational accepts are 0 during reset.
- **Reset mid-transaction:** CS deasserts without waiting for a clock; after release the block is in IDLE with no partial state.
- **Write latency:**
  - accept edge E0 → CS low from E0;
  - command in cycles 1–2, address in cycles 3–6;
  - first data nibble on the pins in cycle 7.
- **Read latency:**
  - command and address in cycles 1–6, dummy in cycles 7–8;
  - first DATA cycle is cycle 9;
  - first `o_sqi_rdata_vld` in cycle 10.
- **Minimum data length** is one nibble (`i_sqi_end` high on the first DATA cycle).
- **Back-to-back requests:** a request held through DESEL is accepted in the IDLE cycle, giving exactly 2 cycles between CS deassertion and reassertion.

## Test plan

- **Write 3 nibbles:** write to addr 0x1234, data 0xA, 0xB, 0xC, `i_sqi_end` on the third DATA cycle.
  - Required: `o_sqi_sio` sequence 0,2,1,2,3,4,A,B,C; CS low for 9 cycles; `o_sqi_wdata_acp` pulses exactly 3 times.
- **Read 2 nibbles:** read from addr 0x00FF; the model returns 0x5 then 0x6.
  - Required: `o_sqi_sio` = 0,3,0,0,F,F; `o_sqi_io_mode` drops at cycle 7; `o_sqi_rdata_vld` in cycles 10–11 with rdata 0x5, 0x6.
- **Back-to-back:** a write followed by a read with `i_sqi_req` held continuously.
  - Required: CS high for exactly 2 cycles between transactions; the second `o_sqi_req_acp` falls in the IDLE cycle.
- **Single-nibble write:** `i_sqi_end` asserted on the first DATA cycle.
  - Required: one data nibble; `o_sqi_wdata_acp` high only on the last ADDR edge.
- **Reset mid-ADDR:** assert `i_sqi_rst_n` low during the third address nibble.
  - Required: CS = 1, io_mode = 1, sio = 0 immediately; after release, a read to 0x0010 completes correctly.
- **Requests while busy:** toggle `i_sqi_req` and `i_sqi_addr` during a read.
  - Required: `o_sqi_req_acp` stays 0 and the address in flight is unchanged.
